// File: rtl/truth_table_sweep_pkg.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_sweep_pkg
// Description : Shared constants for the truth-table sweep stage. It holds the
//               FSM state encodings and the width of the hold counter.
// Revision    : 1.0 - initial release
// ============================================================================
package truth_table_sweep_pkg;

    // FSM state encodings
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_drive = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

    // Hold counter width. HOLD_CYCLES must fit in this width (1..255).
    localparam int c_cnt_w = 8;

endpackage : truth_table_sweep_pkg
`default_nettype wire

// File: rtl/truth_table_sweep_if.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_sweep_if
// Description : Request/stimulus/result bundle for truth_table_sweep.
//               master : requester side. It drives start, expected and y_in
//                        (y_in comes from the block under exercise).
//               slave  : sweep engine. It drives vec_out, busy, done,
//                        table_out, match and mismatch.
// Revision    : 1.0 - initial release
// ============================================================================
interface truth_table_sweep_if #(
    parameter int N_IN = 3
);
    logic                  start;
    logic [(1<<N_IN)-1:0]  expected;
    logic                  y_in;
    logic [N_IN-1:0]       vec_out;
    logic                  busy;
    logic                  done;
    logic [(1<<N_IN)-1:0]  table_out;
    logic                  match;
    logic [(1<<N_IN)-1:0]  mismatch;

    modport master (
        output start, expected, y_in,
        input  vec_out, busy, done, table_out, match, mismatch
    );

    modport slave (
        input  start, expected, y_in,
        output vec_out, busy, done, table_out, match, mismatch
    );
endinterface : truth_table_sweep_if
`default_nettype wire

// File: rtl/truth_table_sweep.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_sweep
// Description : Drives every input vector 0..2**N_IN-1 to a combinational
//               block. Each vector is held for HOLD_CYCLES clocks, and y_in is
//               sampled on the last edge of each window to build a truth-table
//               bitmap. The bitmap is then compared with the expected table
//               that was latched at start.
// Ports       : clk, rst     - clock, synchronous active-high reset
//               bus (slave)  - start/expected/y_in in;
//                              vec_out/busy/done/table_out/match/mismatch out
// Revision    : 1.0 - initial release
// ============================================================================
module truth_table_sweep
    import truth_table_sweep_pkg::*;
#(
    parameter int N_IN        = 3,
    parameter int HOLD_CYCLES = 10
) (
    input  wire logic          clk,
    input  wire logic          rst,
    truth_table_sweep_if.slave bus
);

    localparam int                   c_tbl_w     = 1 << N_IN;
    localparam logic [c_cnt_w-1:0]   c_hold_last = c_cnt_w'(HOLD_CYCLES - 1);
    localparam logic [N_IN-1:0]      c_vec_last  = {N_IN{1'b1}};

    logic [1:0]          r_state;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [N_IN-1:0]     r_vec;
    logic                r_busy;
    logic                r_done;
    logic [c_tbl_w-1:0]  r_table;
    logic [c_tbl_w-1:0]  r_expected;
    logic                r_match;
    logic [c_tbl_w-1:0]  r_mismatch;

    // This is the table as it will be after the current capture. The result
    // compare on the terminal edge uses it so that the last bit is included.
    logic [c_tbl_w-1:0]  w_next_table;

    always_comb begin
        w_next_table        = r_table;
        w_next_table[r_vec] = bus.y_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_cnt      <= '0;
            r_vec      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_table    <= '0;
            r_expected <= '0;
            r_match    <= 1'b0;
            r_mismatch <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_state    <= c_st_drive;
                        r_cnt      <= '0;
                        r_vec      <= '0;
                        r_busy     <= 1'b1;
                        r_table    <= '0;
                        r_match    <= 1'b0;
                        r_mismatch <= '0;
                        r_expected <= bus.expected;
                    end
                end

                c_st_drive: begin
                    if (r_cnt < c_hold_last) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        // End of the hold window: capture this vector's output.
                        r_table <= w_next_table;
                        r_cnt   <= '0;
                        if (r_vec == c_vec_last) begin
                            r_state    <= c_st_done;
                            r_done     <= 1'b1;
                            r_vec      <= '0;
                            r_match    <= (w_next_table == r_expected);
                            r_mismatch <= w_next_table ^ r_expected;
                        end else begin
                            r_vec <= r_vec + 1'b1;
                        end
                    end
                end

                c_st_done: begin
                    r_state <= c_st_idle;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= c_st_idle;
                    r_cnt   <= '0;
                    r_vec   <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.vec_out   = r_vec;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.table_out = r_table;
    assign bus.match     = r_match;
    assign bus.mismatch  = r_mismatch;

endmodule : truth_table_sweep
`default_nettype wire
